// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer blocks.
//
// Contents:
//   SYNC_STAGES : depth of the clock-domain-crossing synchroniser for Gray
//                 pointers (two flops).
//   gray2bin    : Gray-to-binary conversion. The read-side block uses it for
//                 the write pointer. The write side uses it for the read
//                 pointer when FIFO_WR_LEVEL_EN is defined.
package fifo_pkg;

    localparam int SYNC_STAGES = 2;

    // Prefix-XOR from the MSB downwards. Narrower pointers are passed in
    // zero-extended, so the unused upper bits stay zero and do not disturb
    // the result.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/bin2gray.sv
// Binary-to-Gray encoder. This is the shared encoder used by both FIFO
// pointer blocks.
//
// Parameters:
//   BIT_WIDTH : width of the code word.
// Ports:
//   bin  in  BIT_WIDTH  binary value
//   gray out BIT_WIDTH  Gray code of bin (purely combinational)
module bin2gray #(
    parameter int BIT_WIDTH = 5
) (
    input  logic [BIT_WIDTH-1:0] bin,
    output logic [BIT_WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a multi-bit Gray-coded pointer.
//
// The flops have no logic between them. A Gray pointer changes only one bit
// at a time, so the captured word is always either the old value or the new
// value. The read side reuses this block for the write pointer.
//
// Parameters:
//   WIDTH : number of bits carried across the domain boundary.
// Ports:
//   clk  in  1      destination-domain clock
//   rst  in  1      asynchronous, active-high reset (all stages clear to 0)
//   d    in  WIDTH  asynchronous input
//   q    out WIDTH  synchronised output (last stage)
module sync_2ff
    import fifo_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [SYNC_STAGES];

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_r[i] <= stage_r[i - 1];
            end
        end
    end

    assign q = stage_r[SYNC_STAGES - 1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag generator for the asynchronous FIFO.
//
// This block keeps the binary write pointer and exports its Gray form to the
// read domain. It also synchronises the read-domain Gray pointer and produces
// a registered, pessimistic full flag.
//
// Optional feature (macro FIFO_WR_LEVEL_EN):
//   When the macro is defined, the block decodes the synchronised read
//   pointer and adds the wr_level and almost_full outputs.
//
// Parameters:
//   ADDR_WIDTH          : RAM address bits. Depth is 2**ADDR_WIDTH. Must be >= 2.
//   ALMOST_FULL_THRESH  : wr_level at or above which almost_full asserts.
// Ports:
//   clk          in   1             write-domain clock
//   rst          in   1             asynchronous, active-high reset
//   wr_en        in   1             push request
//   rd_gray_ptr  in   ADDR_WIDTH+1  Gray read pointer from the read domain
//   wr_accept    out  1             RAM write strobe (wr_en & ~full)
//   wr_addr      out  ADDR_WIDTH    RAM write address
//   wr_gray_ptr  out  ADDR_WIDTH+1  registered Gray write pointer
//   full         out  1             registered full flag
//   wr_level     out  ADDR_WIDTH+1  conservative fill level (FIFO_WR_LEVEL_EN)
//   almost_full  out  1             wr_level >= ALMOST_FULL_THRESH (FIFO_WR_LEVEL_EN)
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH         = 4,
    parameter int ALMOST_FULL_THRESH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_gray_ptr,
    output logic                  wr_accept,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_gray_ptr,
    output logic                  full
`ifdef FIFO_WR_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  almost_full
`endif
);

    logic [ADDR_WIDTH:0] wbin_r;
    logic [ADDR_WIDTH:0] wgray_r;
    logic                full_r;
    logic [ADDR_WIDTH:0] rq2_s;
    logic [ADDR_WIDTH:0] wbin_next_s;
    logic [ADDR_WIDTH:0] gnext_s;
    logic [ADDR_WIDTH:0] full_cmp_s;

    sync_2ff #(
        .WIDTH (ADDR_WIDTH + 1)
    ) u_rptr_sync (
        .clk (clk),
        .rst (rst),
        .d   (rd_gray_ptr),
        .q   (rq2_s)
    );

    bin2gray #(
        .BIT_WIDTH (ADDR_WIDTH + 1)
    ) u_wptr_enc (
        .bin  (wbin_next_s),
        .gray (gnext_s)
    );

    assign wr_accept   = wr_en & ~full_r;
    assign wbin_next_s = wbin_r + (ADDR_WIDTH + 1)'(wr_accept);

    // The FIFO is full when the write pointer is exactly one lap ahead of
    // the read pointer. In Gray code that condition means the two MSBs are
    // inverted and the remaining bits are equal.
    assign full_cmp_s = {~rq2_s[ADDR_WIDTH:ADDR_WIDTH-1], rq2_s[ADDR_WIDTH-2:0]};

    // Pointer and full-flag registers. The flag is evaluated against the
    // post-push pointer, so the push that fills the last slot raises full
    // on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin_r  <= '0;
            wgray_r <= '0;
            full_r  <= 1'b0;
        end else begin
            wbin_r  <= wbin_next_s;
            wgray_r <= gnext_s;
            full_r  <= (gnext_s == full_cmp_s);
        end
    end

    assign wr_addr     = wbin_r[ADDR_WIDTH-1:0];
    assign wr_gray_ptr = wgray_r;
    assign full        = full_r;

`ifdef FIFO_WR_LEVEL_EN
    logic [ADDR_WIDTH:0] rbin_s;

    // The read pointer lags the read domain by the synchroniser depth, so
    // this level may overstate the fill but never understates it.
    assign rbin_s      = (ADDR_WIDTH + 1)'(gray2bin(32'(rq2_s)));
    assign wr_level    = wbin_r - rbin_s;
    assign almost_full = (wr_level >= (ADDR_WIDTH + 1)'(ALMOST_FULL_THRESH));
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full with ADDR_WIDTH=4.
//
// A vector table covers the fill sequence. Hand-written sequences cover
// release from full, pointer wrap, asynchronous reset and the optional
// level outputs.
module tb_fifo_wptr_full;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW:0]   rd_gray_ptr = '0;
    logic          wr_accept;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   wr_gray_ptr;
    logic          full;
`ifdef FIFO_WR_LEVEL_EN
    logic [AW:0]   wr_level;
    logic          almost_full;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    fifo_wptr_full #(
        .ADDR_WIDTH         (AW),
        .ALMOST_FULL_THRESH (14)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_gray_ptr (rd_gray_ptr),
        .wr_accept   (wr_accept),
        .wr_addr     (wr_addr),
        .wr_gray_ptr (wr_gray_ptr),
        .full        (full)
`ifdef FIFO_WR_LEVEL_EN
        ,
        .wr_level    (wr_level),
        .almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [4:0]  rd_gray;
        logic        exp_accept;
        logic [3:0]  exp_addr;
        logic [4:0]  exp_gray;
        logic        exp_full;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        wr_en       = 1'b0;
        rd_gray_ptr = '0;
        rst         = 1'b1;
        tick();
        tick();
        rst         = 1'b0;
    endtask

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin : main
        logic [4:0] gtab [16];
        logic [4:0] prev_gray;
        logic [4:0] mw;

        gtab = '{5'b00001, 5'b00011, 5'b00010, 5'b00110,
                 5'b00111, 5'b00101, 5'b00100, 5'b01100,
                 5'b01101, 5'b01111, 5'b01110, 5'b01010,
                 5'b01011, 5'b01001, 5'b01000, 5'b11000};
        for (int i = 0; i < 16; i++) begin
            vecs[i].wr_en      = 1'b1;
            vecs[i].rd_gray    = 5'b00000;
            vecs[i].exp_accept = 1'b1;
            vecs[i].exp_addr   = 4'(i + 1);
            vecs[i].exp_gray   = gtab[i];
            vecs[i].exp_full   = (i == 15);
        end
        // One more push request while full: the design must ignore it.
        vecs[16].wr_en      = 1'b1;
        vecs[16].rd_gray    = 5'b00000;
        vecs[16].exp_accept = 1'b0;
        vecs[16].exp_addr   = 4'd0;
        vecs[16].exp_gray   = 5'b11000;
        vecs[16].exp_full   = 1'b1;

        // Reset state.
        #12;
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_gray", 32'(wr_gray_ptr), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        rst = 1'b0;

        // Fill sequence, driven from the vector table.
        for (int i = 0; i < 17; i++) begin
            wr_en       = vecs[i].wr_en;
            rd_gray_ptr = vecs[i].rd_gray;
            #1;
            check($sformatf("accept[%0d]", i), 32'(wr_accept), 32'(vecs[i].exp_accept));
            prev_gray = wr_gray_ptr;
            tick();
            check($sformatf("addr[%0d]", i), 32'(wr_addr), 32'(vecs[i].exp_addr));
            check($sformatf("gray[%0d]", i), 32'(wr_gray_ptr), 32'(vecs[i].exp_gray));
            check($sformatf("full[%0d]", i), 32'(full), 32'(vecs[i].exp_full));
            if (vecs[i].exp_accept) begin
                check($sformatf("gray_1bit[%0d]", i), 32'($countones(prev_gray ^ wr_gray_ptr)), 32'd1);
            end
        end

        // Release from full. The single read becomes visible after the
        // synchroniser, and full clears on the third edge.
        wr_en       = 1'b0;
        rd_gray_ptr = 5'b00001;
        tick();
        check("release_e1", 32'(full), 32'd1);
        tick();
        check("release_e2", 32'(full), 32'd1);
        tick();
        check("release_e3", 32'(full), 32'd0);
        check("release_ptr_hold", 32'(wr_gray_ptr), 32'b11000);

`ifdef FIFO_WR_LEVEL_EN
        // Level: 10 pushes, then the read pointer moves to binary 4.
        apply_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        wr_en       = 1'b0;
        rd_gray_ptr = 5'b00110;
        tick();
        check("level_sync1", 32'(wr_level), 32'd10);
        tick();
        check("level_6", 32'(wr_level), 32'd6);
        check("almost_full_6", 32'(almost_full), 32'd0);
        wr_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        check("level_13", 32'(wr_level), 32'd13);
        check("almost_full_13", 32'(almost_full), 32'd0);
        tick();
        check("level_14", 32'(wr_level), 32'd14);
        check("almost_full_14", 32'(almost_full), 32'd1);
        check("level_not_full", 32'(full), 32'd0);
`endif

        // Wrap: 40 pushes while the reader keeps pace, 31 -> 0 crossing.
        apply_reset();
        mw = 5'd0;
        for (int i = 0; i < 40; i++) begin
            wr_en       = 1'b1;
            rd_gray_ptr = to_gray(mw);
            #1;
            check($sformatf("wrap_accept[%0d]", i), 32'(wr_accept), 32'd1);
            prev_gray = wr_gray_ptr;
            tick();
            mw = mw + 5'd1;
            check($sformatf("wrap_gray[%0d]", i), 32'(wr_gray_ptr), 32'(to_gray(mw)));
            check($sformatf("wrap_full[%0d]", i), 32'(full), 32'd0);
            if (mw == 5'd0) begin
                check("wrap_prev_gray", 32'(prev_gray), 32'b10000);
                check("wrap_addr", 32'(wr_addr), 32'd0);
            end
        end

        // Asynchronous reset mid-traffic, asserted between clock edges.
        wr_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_addr", 32'(wr_addr), 32'd0);
        check("async_rst_gray", 32'(wr_gray_ptr), 32'd0);
        check("async_rst_full", 32'(full), 32'd0);
        tick();
        check("rst_hold_gray", 32'(wr_gray_ptr), 32'd0);
        rst   = 1'b0;
        wr_en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
